// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to a synchronous
// instruction memory and buffers returned instructions in an in-order queue.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pend_pc;
    logic              pending;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  occupancy;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic              push;
    logic              pop;
    logic              unused_addr_bits;

    // Redirect targets are forced to word alignment, so the low bits are dropped.
    assign unused_addr_bits = ^redirect_pc[1:0];

    // Queued plus in-flight entries must never exceed the queue capacity.
    assign occupancy   = count + CNT_W'(pending);
    assign imem_req    = (state == RUN) && (occupancy < CNT_W'(DEPTH)) && !redirect;
    assign imem_addr   = pc;
    assign push        = pending && !redirect;
    assign instr_valid = (count != '0);
    assign pop         = instr_valid && instr_ready;
    assign instr       = instr_valid ? data_q[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? pc_q[rd_ptr]   : '0;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            pend_pc <= '0;
            pending <= 1'b0;
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            if (state == IDLE) begin
                state <= RUN;
            end

            if (redirect) begin
                pc      <= {redirect_pc[ADDR_W-1:2], 2'b00};
                pending <= 1'b0;
                count   <= '0;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
            end else begin
                if (imem_req) begin
                    pc      <= pc + ADDR_W'(4);
                    pend_pc <= pc;
                end
                pending <= imem_req;

                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end

                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // NOTE: queue storage has no reset; entries are only observed once count
    // marks them valid, and the outputs are masked to zero otherwise.
    always_ff @(posedge clock) begin
        if (push) begin
            data_q[wr_ptr] <= imem_rdata;
            pc_q[wr_ptr]   <= pend_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a synchronous memory model plus a
// queue-based reference of fetch order, flushes and back-pressure.
module tb_instr_fetch_unit;

    localparam int          ADDR_W   = 32;
    localparam int          DATA_W   = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata = '0;
    logic              redirect = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready = 1'b0;

    always #5 clock = ~clock;

    instr_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Synchronous memory: data for a request appears the following cycle,
    // otherwise the bus carries junk that must never reach the queue.
    always @(posedge clock) begin
        if (imem_req === 1'b1) imem_rdata <= mem_word(imem_addr);
        else                   imem_rdata <= $urandom();
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    entry_t      fifo[$];
    bit          in_flight;
    logic [31:0] flight_pc;
    logic [31:0] model_pc;
    bit          model_run;
    int          cyc;
    int          req_seen;
    int          compared = 0;
    int          mismatched = 0;

    task automatic model_reset();
        fifo.delete();
        in_flight = 1'b0;
        flight_pc = '0;
        model_pc  = RESET_PC;
        model_run = 1'b0;
        cyc       = 0;
        req_seen  = 0;
    endtask

    // One clock cycle: drive inputs after the falling edge, compare against the
    // reference, then advance the reference across the coming rising edge.
    task automatic step(input bit rd, input bit redir, input logic [31:0] rpc);
        bit     exp_req;
        bit     exp_valid;
        entry_t head;
        @(negedge clock);
        instr_ready = rd;
        redirect    = redir;
        redirect_pc = rpc;
        #1;
        exp_req   = model_run && (fifo.size() + int'(in_flight) < DEPTH) && !redir;
        exp_valid = fifo.size() > 0;

        compared++;
        if (imem_req !== exp_req) begin
            mismatched++;
            $display("FAIL imem_req cyc %0d: got %b want %b", cyc, imem_req, exp_req);
        end
        if (exp_req) begin
            compared++;
            if (imem_addr !== model_pc) begin
                mismatched++;
                $display("FAIL imem_addr cyc %0d: got %h want %h", cyc, imem_addr, model_pc);
            end
        end
        compared++;
        if (instr_valid !== exp_valid) begin
            mismatched++;
            $display("FAIL instr_valid cyc %0d: got %b want %b", cyc, instr_valid, exp_valid);
        end
        if (exp_valid) begin
            head = fifo[0];
            compared++;
            if (instr_pc !== head.pc || instr !== head.data) begin
                mismatched++;
                $display("FAIL head cyc %0d: got pc %h instr %h want pc %h instr %h",
                         cyc, instr_pc, instr, head.pc, head.data);
            end
        end
        if (imem_req === 1'b1) req_seen++;

        if (redir) begin
            fifo.delete();
            in_flight = 1'b0;
            model_pc  = rpc & ~32'h3;
        end else begin
            if (exp_valid && rd) void'(fifo.pop_front());
            if (in_flight) fifo.push_back('{pc: flight_pc, data: mem_word(flight_pc)});
            in_flight = exp_req;
            if (exp_req) begin
                flight_pc = model_pc;
                model_pc  = model_pc + 32'd4;
            end
        end
        model_run = 1'b1;
        cyc++;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset_n     = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset_n = 1'b0;
        #2;
        compared++;
        if (imem_req !== 1'b0 || imem_addr !== RESET_PC || instr_valid !== 1'b0 ||
            instr !== '0 || instr_pc !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got req %b addr %h valid %b instr %h pc %h want 0 %h 0 0 0",
                     imem_req, imem_addr, instr_valid, instr, instr_pc, RESET_PC);
        end
        apply_reset();
    endtask

    task automatic test_streaming();
        apply_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);
        compared++;
        if (instr_valid !== 1'b1 || instr_pc !== RESET_PC) begin
            mismatched++;
            $display("FAIL first_valid_cycle3: got valid %b pc %h want 1 %h", instr_valid, instr_pc, RESET_PC);
        end
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, '0);
    endtask

    task automatic test_backpressure();
        apply_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0);
        compared++;
        if (req_seen !== DEPTH) begin
            mismatched++;
            $display("FAIL stall_requests: got %0d want %0d", req_seen, DEPTH);
        end
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, '0);
    endtask

    task automatic test_redirect();
        apply_reset();
        // Cycles 0..4 with no consumer leave three queued and one in flight.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 32'h0000_0100);
        step(1'b1, 1'b0, '0);
        compared++;
        if (instr_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL redirect_flush: got valid %b want 0", instr_valid);
        end
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        compared++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0000_0100) begin
            mismatched++;
            $display("FAIL redirect_target: got valid %b pc %h want 1 00000100", instr_valid, instr_pc);
        end
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 32'h0000_0103);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom());
        end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);
        #1;
        reset_n = 1'b0;
        #1;
        compared++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== RESET_PC) begin
            mismatched++;
            $display("FAIL async_reset: got req %b valid %b addr %h want 0 0 %h",
                     imem_req, instr_valid, imem_addr, RESET_PC);
        end
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        model_reset();
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        compared++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            mismatched++;
            $display("FAIL restart_cycle1: got req %b addr %h want 1 %h", imem_req, imem_addr, RESET_PC);
        end
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect();
        test_random();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage placed directly upstream of `DataPath`. It holds the program counter and issues word reads to a synchronous instruction memory. Returned instructions go into a small in-order queue, and the datapath drains that queue through a valid/ready handshake. A redirect from the datapath (branch or jump) flushes every queued and in-flight instruction and restarts fetch at the new address.

## Interface
- `ADDR_W`, 32, width of PC and instruction-memory address
- `DATA_W`, 32, instruction width
- `DEPTH`, 4, instruction queue entries (power of two, ≥2)
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clock`  in  1  single clock, all flops rising-edge
- `reset_n`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  read request to instruction memory this cycle
- `imem_addr`  out  ADDR_W  read address, always word aligned
- `imem_rdata`  in  DATA_W  read data, valid the cycle after `imem_req`
- `redirect`  in  1  one-cycle pulse: flush and refetch
- `redirect_pc`  in  ADDR_W  new fetch address, sampled when `redirect`=1
- `instr_valid`  out  1  queue head is valid
- `instr`  out  DATA_W  queue head instruction
- `instr_pc`  out  ADDR_W  address of `instr`
- `instr_ready`  in  1  datapath accepts the head this cycle

## Operation
- State machine has two states: IDLE (reset state) and RUN.
  - IDLE→RUN on the first rising edge with `reset_n`=1.
  - RUN persists until reset.
- Request rule: in RUN, `imem_req` = (`count` + `pending` < DEPTH) && !`redirect`.
  - `count` is the number of queued entries.
  - `pending` is 1 when a response is due this cycle.
  - In IDLE, `imem_req`=0.
- `imem_addr` = `pc`. On each issued request, `pc` ← `pc`+4. The issued address is latched as `pend_pc` and `pending` ← 1.
- Response cycle (`pending`=1, not killed): push {`imem_rdata`, `pend_pc`} at the queue tail.
- Pop when `instr_valid` && `instr_ready`. Push and pop in the same cycle leave `count` unchanged.
- Redirect has priority over push and request:
  - queue cleared; the response due this cycle is discarded;
  - `pending` ← 0;
  - `pc` ← {`redirect_pc`[ADDR_W-1:2], 2'b00} (low two bits ignored).
- A pop handshake in the redirect cycle still counts as consumed.
- PC arithmetic is modulo 2^ADDR_W. 0xFFFF_FFFC+4 wraps to 0x0000_0000 with no flag.
- Queue pointers wrap modulo DEPTH. `count` ranges 0..DEPTH. The request rule makes overflow impossible.
- Queue order equals fetch order: no reordering, duplication or loss except on a redirect flush.
- `instr`/`instr_pc` are meaningful only while `instr_valid`=1.

## Timing
- Reset (async, immediate): state=IDLE, `pc`=RESET_PC, `count`=0, `pending`=0.
  - Outputs: `imem_req`=0, `imem_addr`=RESET_PC, `instr_valid`=0, `instr`=0, `instr_pc`=0.
- Cycle numbering below counts from the first cycle after reset is released (cycle 0).
- Cycle 0: IDLE, no request.
- Cycle 1: first request at RESET_PC.
- Cycle 2: response pushed.
- Cycle 3: `instr_valid`=1 for RESET_PC.
- Fetch-to-issue latency is 2 cycles: request in cycle N, `instr_valid` in N+2.
- With `instr_ready` held high, throughput is 1 instruction/cycle after fill.
- Redirect pulsed in cycle R:
  - no request in R;
  - `instr_valid`=0 in R+1;
  - request for the new PC in R+1;
  - its instruction is valid in R+3.
- Back-pressure: with `instr_ready`=0, requests stop once `count`+`pending`=DEPTH. They resume the cycle after a pop frees an entry.
- Reset asserted mid-operation discards all state immediately. After release, the sequence restarts from cycle 0 above.

## Test plan
- Reset, then hold `instr_ready`=1 with a memory model returning data=addr^32'hA5A5_0000 → `instr_pc` shows 0,4,8,… in consecutive cycles from cycle 3, and `instr` matches the model.
- Hold `instr_ready`=0 from reset → exactly 4 requests (0x0–0xC), then `imem_req`=0. Raise `instr_ready` → 0x0,0x4,0x8,0xC delivered in order, fetch resumes at 0x10, no gaps or repeats.
- With 3 entries queued and 1 in flight, pulse `redirect` with `redirect_pc`=0x100 → `instr_valid`=0 the next cycle, next delivered `instr_pc`=0x100 three cycles after the pulse, no stale instruction ever appears.
- Redirect to 0x103 → fetch addresses 0x100, 0x104.
- Redirect to 0xFFFF_FFF8 → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap).
- Assert `reset_n`=0 mid-stream between edges → `instr_valid` and `imem_req` drop immediately. After release, the first request is RESET_PC in cycle 1.
